ov7670_frame_capture: RTL and testbench
=======================================

// Module: ov7670_frame_capture
// PURPOSE
//  Captures one frame of byte-serial pixel data from an OV7670 camera (DVP bus: vsync, href, d)
//  and emits a byte-wide framebuffer write stream (addr, dout, we).
//  Sits between the sensor pins and a single-port frame RAM, in the sensor's pixel-clock domain.
//  Capture is armed by software via start; exactly one complete frame is stored per arm.
// PARAMETERS
//  MAX_BYTES   38400   bytes stored per frame (default 160x120 RGB565); must be <= 65536
//  ADDR_W      16      framebuffer address width
// PORTS
//  pclk_24   in   1       sensor pixel clock (24 MHz); the only clock; all logic on rising edge
//  reset_n   in   1       asynchronous active-low reset
//  start     in   1       arm capture; sampled on pclk_24; level or pulse, acts on any cycle it is 1 in IDLE
//  vsync     in   1       sensor vertical sync, active high during frame blanking
//  href      in   1       sensor line valid; d is a valid byte on every cycle href=1
//  d         in   8       sensor pixel byte
//  addr      out  ADDR_W  framebuffer byte address of the byte on dout
//  dout      out  8       byte to write
//  we        out  1       write strobe; addr/dout valid when 1 (extra port, leave open if unused)
//  done      out  1       one-cycle pulse after a frame has been fully captured
// BEHAVIOUR
//  Reset: state=IDLE; addr=0, dout=0, we=0, done=0, internal byte counter cnt=0.
//  States:
//   IDLE      : start=1 -> WAIT_VS (cnt<=0).
//   WAIT_VS   : wait for vsync=1 (frame blanking) -> WAIT_FS. Guarantees that a frame is never joined mid-way.
//   WAIT_FS   : vsync 1->0 (frame start) -> CAPTURE.
//   CAPTURE   : each cycle with href=1 and cnt<MAX_BYTES: dout<=d, addr<=cnt, we<=1, cnt<=cnt+1.
//               Cycles with href=0: we<=0, addr/dout hold.
//               vsync=1 (next frame's blanking) -> DONE.
//   DONE      : done<=1 for one cycle, we<=0 -> IDLE.
//  Latency: the byte present with href=1 at edge N appears on dout with we=1 after edge N (1 cycle).
//  The first byte of a frame is written at addr 0; addresses are strictly consecutive across lines
//  (href gaps do not skip addresses).
//  Overflow: once cnt=MAX_BYTES, further href bytes are dropped (we=0); addr never wraps.
//  Short frame: if vsync rises before MAX_BYTES, the frame still ends -> DONE; cnt is not padded.
//  start is ignored outside IDLE (re-arm only after done).
//  vsync=1 on the same cycle as href=1 in CAPTURE: vsync wins, the byte is not written.
//  Asynchronous reset mid-capture: all outputs return to reset values immediately; the partial frame is abandoned.
//  cnt is ADDR_W+1 bits wide so that MAX_BYTES=65536 is representable.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Single module, no sub-modules. State encoding as a localparam enum (IDLE, WAIT_VS, WAIT_FS,
//  CAPTURE, DONE) in a shared package ov7670_pkg, together with the default frame geometry constants
//  (QQVGA_W=160, QQVGA_H=120, BYTES_PER_PIX=2).
// TESTING
//  1 Reset: reset_n=0 for 3 clocks with random inputs -> addr=0, dout=0, we=0, done=0.
//  2 Basic frame: MAX_BYTES=8, start pulse, vsync 1->0, 2 lines of href=1 x4 with d=0x10..0x17,
//    2-cycle gap between the lines -> writes addr 0..7 with dout 0x10..0x17, we low during the gap, then vsync=1 -> done pulse.
//  3 Mid-frame arm: start while vsync=0 and href toggling -> no writes until vsync has risen then fallen.
//  4 Overflow: MAX_BYTES=4, 6 href bytes -> only addr 0..3 written; we=0 for bytes 5-6; done after vsync.
//  5 Ignore/re-arm: start held during CAPTURE -> no restart; after done, start again -> second frame begins at addr 0.
//  6 Async reset mid-capture at byte 3 -> outputs cleared without waiting for a clock edge; state IDLE; start required to capture again.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and default geometry for the OV7670 frame capture block.
package ov7670_pkg;

   localparam int QQVGA_W       = 160;
   localparam int QQVGA_H       = 120;
   localparam int BYTES_PER_PIX = 2;
   localparam int DEF_MAX_BYTES = QQVGA_W * QQVGA_H * BYTES_PER_PIX;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      WAIT_FS = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } cap_state_t;

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// Sensor-side DVP inputs plus the framebuffer write stream of the capture block.
interface ov7670_frame_capture_if #(
   parameter int ADDR_W = 16
);

   logic              start;
   logic              vsync;
   logic              href;
   logic [7:0]        d;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        dout;
   logic              we;
   logic              done;

   // master drives the sensor/control side, slave is the capture block
   modport master (
      output start, vsync, href, d,
      input  addr, dout, we, done
   );

   modport slave (
      input  start, vsync, href, d,
      output addr, dout, we, done
   );

endinterface

// File: rtl/ov7670_frame_capture.sv
// Captures exactly one DVP frame per arm and streams it out as consecutive byte writes.
module ov7670_frame_capture
   import ov7670_pkg::*;
#(
   parameter int MAX_BYTES = DEF_MAX_BYTES,
   parameter int ADDR_W    = 16
) (
   input  logic                   pclk_24,
   input  logic                   reset_n,
   ov7670_frame_capture_if.slave  bus
);

   // cnt carries one extra bit so a full 2**ADDR_W frame fits
   localparam logic [ADDR_W:0] MAX_CNT = MAX_BYTES[ADDR_W:0];

   cap_state_t      state;
   logic [ADDR_W:0] cnt;

   always_ff @(posedge pclk_24 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bus.addr <= '0;
         bus.dout <= '0;
         bus.we   <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.we   <= 1'b0;
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  cnt   <= '0;
                  state <= WAIT_VS;
               end
            end
            WAIT_VS: begin
               if (bus.vsync) state <= WAIT_FS;
            end
            WAIT_FS: begin
               if (!bus.vsync) state <= CAPTURE;
            end
            CAPTURE: begin
               // vsync has priority: a byte coinciding with the next blanking is dropped
               if (bus.vsync) begin
                  state <= DONE;
               end else if (bus.href && (cnt < MAX_CNT)) begin
                  bus.dout <= bus.d;
                  bus.addr <= cnt[ADDR_W-1:0];
                  bus.we   <= 1'b1;
                  cnt      <= cnt + 1'b1;
               end
            end
            DONE: begin
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Self-checking bench: two capture instances (8-byte and 4-byte frames) against a byte-list frame model.
module tb_ov7670_frame_capture;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ov7670_frame_capture_if #(.ADDR_W(16)) bus_a ();
   ov7670_frame_capture_if #(.ADDR_W(16)) bus_b ();

   ov7670_frame_capture #(.MAX_BYTES(8), .ADDR_W(16)) dut_a (
      .pclk_24 (clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   ov7670_frame_capture #(.MAX_BYTES(4), .ADDR_W(16)) dut_b (
      .pclk_24 (clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   int  n_assert = 0;
   int  n_fail   = 0;
   wr_t got_a[$];
   wr_t got_b[$];
   wr_t exp_q[$];
   int  done_a = 0;
   int  done_b = 0;

   always @(negedge clk) begin
      if (bus_a.we === 1'b1) got_a.push_back(wr_t'({bus_a.addr, bus_a.dout}));
      if (bus_b.we === 1'b1) got_b.push_back(wr_t'({bus_b.addr, bus_b.dout}));
      if (bus_a.done === 1'b1) done_a++;
      if (bus_b.done === 1'b1) done_b++;
   end

   task automatic tick(input int sel, input logic st, input logic vs, input logic hr, input logic [7:0] dd);
      if (sel == 0) begin
         bus_a.start = st; bus_a.vsync = vs; bus_a.href = hr; bus_a.d = dd;
      end else begin
         bus_b.start = st; bus_b.vsync = vs; bus_b.href = hr; bus_b.d = dd;
      end
      @(negedge clk);
   endtask

   // Frame model: every href byte after the vsync fall is numbered in arrival order;
   // the first maxb of them are the expected writes, at address equal to their number.
   task automatic run_frame(input int sel, input int maxb, input bit arm, input bit hold,
                            input bit expect_cap, input int nlines, input int maxlen);
      int idx = 0;
      logic [7:0] b;
      if (arm) tick(sel, 1'b1, 1'b0, 1'b0, 8'h00);
      repeat (2) tick(sel, hold, 1'b1, 1'b0, 8'($urandom));
      repeat (2) tick(sel, hold, 1'b0, 1'b0, 8'($urandom));
      for (int l = 0; l < nlines; l++) begin
         int len = $urandom_range(1, maxlen);
         for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            tick(sel, hold, 1'b0, 1'b1, b);
            if (expect_cap && idx < maxb) exp_q.push_back(wr_t'({16'(idx), b}));
            idx++;
         end
         repeat ($urandom_range(1, 3)) tick(sel, hold, 1'b0, 1'b0, 8'($urandom));
      end
      tick(sel, 1'b0, 1'b1, 1'b1, 8'($urandom));
      repeat (3) tick(sel, 1'b0, 1'b1, 1'b0, 8'($urandom));
      tick(sel, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_b.start = 1'($urandom); bus_b.vsync = 1'($urandom);
         bus_b.href = 1'($urandom); bus_b.d = 8'($urandom);
         tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      end
      n_assert += 8;
      if (bus_a.addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr_a: got %h expected 0", bus_a.addr); end
      if (bus_a.dout !== 8'h0)  begin n_fail++; $display("FAIL reset_dout_a: got %h expected 0", bus_a.dout); end
      if (bus_a.we !== 1'b0)    begin n_fail++; $display("FAIL reset_we_a: got %b expected 0", bus_a.we); end
      if (bus_a.done !== 1'b0)  begin n_fail++; $display("FAIL reset_done_a: got %b expected 0", bus_a.done); end
      if (bus_b.addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr_b: got %h expected 0", bus_b.addr); end
      if (bus_b.dout !== 8'h0)  begin n_fail++; $display("FAIL reset_dout_b: got %h expected 0", bus_b.dout); end
      if (bus_b.we !== 1'b0)    begin n_fail++; $display("FAIL reset_we_b: got %b expected 0", bus_b.we); end
      if (bus_b.done !== 1'b0)  begin n_fail++; $display("FAIL reset_done_b: got %b expected 0", bus_b.done); end
      bus_b.start = 1'b0; bus_b.vsync = 1'b0; bus_b.href = 1'b0; bus_b.d = 8'h00;
      tick(0, 1'b0, 1'b0, 1'b0, 8'h00);
      reset_n = 1'b1;
      tick(0, 1'b0, 1'b0, 1'b0, 8'h00);
      got_a.delete(); got_b.delete();
   endtask

   task automatic test_basic_frame;
      logic [7:0] exp_d;
      tick(0, 1'b1, 1'b0, 1'b0, 8'h00);
      repeat (2) tick(0, 1'b0, 1'b1, 1'b0, 8'h00);
      repeat (2) tick(0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            repeat (2) begin
               tick(0, 1'b0, 1'b0, 1'b0, 8'hAA);
               n_assert++;
               if (bus_a.we !== 1'b0) begin n_fail++; $display("FAIL basic_gap_we: got %b expected 0", bus_a.we); end
            end
         end
         exp_d = 8'(8'h10 + i);
         tick(0, 1'b0, 1'b0, 1'b1, exp_d);
         n_assert++;
         if (bus_a.we !== 1'b1 || bus_a.addr !== 16'(i) || bus_a.dout !== exp_d) begin
            n_fail++;
            $display("FAIL basic_write[%0d]: got we=%b addr=%h dout=%h expected we=1 addr=%h dout=%h",
                     i, bus_a.we, bus_a.addr, bus_a.dout, 16'(i), exp_d);
         end
      end
      tick(0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_assert++;
      if (bus_a.we !== 1'b0 || bus_a.done !== 1'b0) begin
         n_fail++; $display("FAIL basic_vsync_edge: got we=%b done=%b expected 0 0", bus_a.we, bus_a.done);
      end
      tick(0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_assert++;
      if (bus_a.done !== 1'b1) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 1", bus_a.done); end
      tick(0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_assert++;
      if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", bus_a.done); end
      tick(0, 1'b0, 1'b0, 1'b0, 8'h00);
      got_a.delete();
   endtask

   task automatic test_random_frames;
      for (int f = 0; f < 4; f++) begin
         int d0 = done_a;
         got_a.delete(); exp_q.delete();
         run_frame(0, 8, 1'b1, 1'b0, 1'b1, $urandom_range(1, 3), 5);
         n_assert++;
         if (got_a.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count[%0d]: got %0d writes expected %0d", f, got_a.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < got_a.size()) begin
            n_assert++;
            if (got_a[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand_write[%0d][%0d]: got %h expected %h", f, i, got_a[i], exp_q[i]);
            end
         end
         n_assert++;
         if (done_a - d0 !== 1) begin n_fail++; $display("FAIL rand_done[%0d]: got %0d pulses expected 1", f, done_a - d0); end
      end
   endtask

   task automatic test_mid_frame_arm;
      got_a.delete(); exp_q.delete();
      for (int i = 0; i < 8; i++) tick(0, (i < 2), 1'b0, 1'(i % 2), 8'($urandom));
      n_assert++;
      if (got_a.size() !== 0) begin n_fail++; $display("FAIL midarm_early: got %0d writes expected 0", got_a.size()); end
      run_frame(0, 8, 1'b0, 1'b0, 1'b1, 2, 3);
      n_assert++;
      if (got_a.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL midarm_count: got %0d writes expected %0d", got_a.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_a.size()) begin
         n_assert++;
         if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL midarm_write[%0d]: got %h expected %h", i, got_a[i], exp_q[i]); end
      end
   endtask

   task automatic test_overflow;
      logic [7:0] b;
      logic [7:0] last_d = 8'h00;
      int d0 = done_b;
      tick(1, 1'b1, 1'b0, 1'b0, 8'h00);
      repeat (2) tick(1, 1'b0, 1'b1, 1'b0, 8'h00);
      repeat (2) tick(1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         tick(1, 1'b0, 1'b0, 1'b1, b);
         n_assert++;
         if (i < 4) begin
            last_d = b;
            if (bus_b.we !== 1'b1 || bus_b.addr !== 16'(i) || bus_b.dout !== b) begin
               n_fail++; $display("FAIL ovf_write[%0d]: got we=%b addr=%h dout=%h expected we=1 addr=%h dout=%h",
                                  i, bus_b.we, bus_b.addr, bus_b.dout, 16'(i), b);
            end
         end else if (bus_b.we !== 1'b0 || bus_b.addr !== 16'd3 || bus_b.dout !== last_d) begin
            n_fail++; $display("FAIL ovf_drop[%0d]: got we=%b addr=%h dout=%h expected we=0 addr=0003 dout=%h",
                               i, bus_b.we, bus_b.addr, bus_b.dout, last_d);
         end
      end
      repeat (3) tick(1, 1'b0, 1'b1, 1'b0, 8'h00);
      tick(1, 1'b0, 1'b0, 1'b0, 8'h00);
      n_assert++;
      if (done_b - d0 !== 1) begin n_fail++; $display("FAIL ovf_done: got %0d pulses expected 1", done_b - d0); end
      got_b.delete(); exp_q.delete();
      run_frame(1, 4, 1'b1, 1'b0, 1'b1, 2, 4);
      n_assert++;
      if (got_b.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL ovf_rand_count: got %0d writes expected %0d", got_b.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_b.size()) begin
         n_assert++;
         if (got_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_rand_write[%0d]: got %h expected %h", i, got_b[i], exp_q[i]); end
      end
   endtask

   task automatic test_rearm;
      int d0 = done_a;
      for (int f = 0; f < 2; f++) begin
         got_a.delete(); exp_q.delete();
         run_frame(0, 8, 1'b1, (f == 0), 1'b1, 2, 3);
         n_assert++;
         if (got_a.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rearm_count[%0d]: got %0d writes expected %0d", f, got_a.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < got_a.size()) begin
            n_assert++;
            if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL rearm_write[%0d][%0d]: got %h expected %h", f, i, got_a[i], exp_q[i]); end
         end
      end
      n_assert++;
      if (done_a - d0 !== 2) begin n_fail++; $display("FAIL rearm_done: got %0d pulses expected 2", done_a - d0); end
   endtask

   task automatic test_async_reset;
      int d0;
      tick(0, 1'b1, 1'b0, 1'b0, 8'h00);
      repeat (2) tick(0, 1'b0, 1'b1, 1'b0, 8'h00);
      repeat (2) tick(0, 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) tick(0, 1'b0, 1'b0, 1'b1, 8'($urandom));
      n_assert++;
      if (bus_a.we !== 1'b1 || bus_a.addr !== 16'd2) begin
         n_fail++; $display("FAIL arst_pre: got we=%b addr=%h expected we=1 addr=0002", bus_a.we, bus_a.addr);
      end
      bus_a.href = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_assert++;
      if (bus_a.we !== 1'b0 || bus_a.addr !== 16'h0 || bus_a.dout !== 8'h0 || bus_a.done !== 1'b0) begin
         n_fail++; $display("FAIL arst_clear: got we=%b addr=%h dout=%h done=%b expected all 0",
                            bus_a.we, bus_a.addr, bus_a.dout, bus_a.done);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick(0, 1'b0, 1'b0, 1'b0, 8'h00);
      got_a.delete(); exp_q.delete();
      d0 = done_a;
      run_frame(0, 8, 1'b0, 1'b0, 1'b0, 2, 3);
      n_assert++;
      if (got_a.size() !== 0 || done_a !== d0) begin
         n_fail++; $display("FAIL arst_no_arm: got %0d writes %0d done expected 0 0", got_a.size(), done_a - d0);
      end
      run_frame(0, 8, 1'b1, 1'b0, 1'b1, 2, 3);
      n_assert++;
      if (got_a.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL arst_rearm_count: got %0d writes expected %0d", got_a.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_a.size()) begin
         n_assert++;
         if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL arst_rearm_write[%0d]: got %h expected %h", i, got_a[i], exp_q[i]); end
      end
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.vsync = 1'b0; bus_a.href = 1'b0; bus_a.d = 8'h00;
      bus_b.start = 1'b0; bus_b.vsync = 1'b0; bus_b.href = 1'b0; bus_b.d = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic_frame();
      test_random_frames();
      test_mid_frame_arm();
      test_overflow();
      test_rearm();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
